// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enable/flush control for the 5-stage core.
// Handles memory freeze, branch flush, load-use and HI/LO hazards, plus the MDU busy window.
module pipe_hazard_ctrl #(
    parameter int REGW    = 5,
    parameter int MDU_LAT = 32,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_hilo,
    input  logic            mdu_start,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rt,
    input  logic            ex_branch_taken,
    input  logic            mem_wait,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            mdu_busy,
    output logic [CNTW-1:0] stall_cycles
);
    localparam int CW = $clog2(MDU_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [CNTW-1:0] r_stall;
    logic            w_load_use, w_hilo_hz, w_issue;

    assign mdu_busy     = (r_state == BUSY);
    assign stall_cycles = r_stall;
    assign w_load_use   = ex_memread && (ex_rt != '0) && (ex_rt == id_rs || ex_rt == id_rt);
    assign w_hilo_hz    = mdu_busy && (id_uses_hilo || mdu_start);
    assign w_issue      = ifid_en && !idex_flush && !mem_wait;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!reset) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush} = 2'b11;
        end else if (mem_wait) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (ex_branch_taken) begin
            {ifid_flush, idex_flush} = 2'b11;
        end else if (w_load_use || w_hilo_hz) begin
            // bubble into EX while the older stages drain
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (r_state == BUSY) begin
            w_cnt_next = r_cnt - 1'b1;
            w_next     = (r_cnt == '0) ? IDLE : BUSY;
        end else if (w_issue && mdu_start) begin
            w_next     = BUSY;
            w_cnt_next = CW'(MDU_LAT - 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (!pc_en && r_stall != '1)
                r_stall <= r_stall + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int LAT  = 4;
    localparam int SMAX = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_hilo = 1'b0, mdu_start = 1'b0, ex_memread = 1'b0;
    logic       ex_branch_taken = 1'b0, mem_wait = 1'b0;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mdu_busy;
    logic [3:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int m_left = 0;
    int m_stall = 0;

    pipe_hazard_ctrl #(.REGW(5), .MDU_LAT(LAT), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_hilo(id_uses_hilo), .mdu_start(mdu_start), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mdu_busy};
    endfunction

    // Drive one cycle, compare against the priority rules, then advance the model over the edge.
    task automatic cycle(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                         input logic hilo, input logic ms, input logic mr,
                         input logic [4:0] ert, input logic br, input logic mw);
        logic lu, hz, busy, issue;
        logic [7:0] exp;
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_uses_hilo = hilo; mdu_start = ms;
        ex_memread = mr; ex_rt = ert; ex_branch_taken = br; mem_wait = mw;
        #1;
        busy = (m_left > 0);
        lu = mr && ert != 0 && (ert == rs || ert == rt);
        hz = busy && (hilo || ms);
        if (mw)           exp = {5'b00000, 2'b00, busy};
        else if (br)      exp = {5'b11111, 2'b11, busy};
        else if (lu || hz) exp = {5'b00111, 2'b01, busy};
        else              exp = {5'b11111, 2'b00, busy};
        chk({tag, "_ctl"}, 32'(ctl()), 32'(exp));
        chk({tag, "_stall"}, 32'(stall_cycles), 32'(m_stall));
        issue = exp[6] && !exp[1] && !mw;
        if (m_left > 0) m_left--;
        else if (issue && ms) m_left = LAT;
        if (!exp[7]) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl()), 32'h06);
        chk("rst_stall", 32'(stall_cycles), 32'h0);
        m_left = 0;
        m_stall = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #3;
        chk("rst_ctl", 32'(ctl()), 32'h06);
        chk("rst_stall", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle("idle0");
        cycle("lu5", 5'd5, 5'd7, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        idle("lu_after");
        cycle("lu0", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        cycle("br_lu", 5'd1, 5'd3, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("frz", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        cycle("frz_br", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle("frz_after");
        cycle("mult", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < LAT + 1; i++) cycle("mfhi", 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle("mdu_after");
        cycle("sq", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        idle("sq_after");
        cycle("mult2", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle("busy1");
        do_reset();
        idle("post_rst");
        for (int i = 0; i < 20; i++) cycle("sat", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle("sat_hold");
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 5) == 0));
            if (i == 200) do_reset();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Drives the enable and synchronous-clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves memory wait, taken-branch flush, load-use hazards and multi-cycle mult/div (HI/LO) hazards.
- Sequences the MDU busy window and counts stall cycles for performance monitoring.

Parameters:
- REGW, 5, register index width.
- MDU_LAT, 32, mult/div occupancy in cycles (≥2).
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REGW  rs index of the instruction in ID.
- id_rt  in  REGW  rt index of the instruction in ID.
- id_uses_hilo  in  1  ID instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo).
- mdu_start  in  1  ID instruction is mult, multu, div or divu.
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  REGW  load destination index in EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_wait  in  1  data memory not ready this cycle.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID enable.
- idex_en  out  1  ID/EX enable.
- exmem_en  out  1  EX/MEM enable.
- memwb_en  out  1  MEM/WB enable.
- ifid_flush  out  1  IF/ID synchronous clear.
- idex_flush  out  1  ID/EX synchronous clear.
- mdu_busy  out  1  MDU occupied.
- stall_cycles  out  CNTW  saturating count of cycles with pc_en=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM → IDLE, MDU counter=0, stall_cycles=0.
  - Outputs forced: all *_en=0, ifid_flush=1, idex_flush=1, mdu_busy=0.
  - Reset mid-MDU-operation aborts it; mdu_busy=0 immediately.
- Enables and flushes are combinational from the current inputs and state. Priority is evaluated per cycle, highest first:
  1. mem_wait=1 (FREEZE): all *_en=0, both flushes=0. Overrides branch and hazards; the branch is re-evaluated on the cycle mem_wait drops.
  2. ex_branch_taken=1 (FLUSH): all *_en=1, ifid_flush=1, idex_flush=1. Any hazard involving the ID instruction is discarded because that instruction is squashed.
  3. Load-use: ex_memread=1 and ex_rt≠0 and (ex_rt==id_rs or ex_rt==id_rt).
     - pc_en=0, ifid_en=0, idex_flush=1 (bubble).
     - exmem_en=1, memwb_en=1, idex_en=1.
     - Exactly one bubble per load.
  4. HI/LO hazard: mdu_busy=1 and (id_uses_hilo=1 or mdu_start=1). Same stall pattern as load-use, held until mdu_busy drops.
  5. Otherwise: all *_en=1, flushes=0.
- ID advances ("issue") when ifid_en=1, idex_flush=0 and mem_wait=0.
- MDU FSM:
  - States IDLE, BUSY.
  - IDLE→BUSY on issue with mdu_start=1; counter loads MDU_LAT-1.
  - BUSY: counter decrements every cycle, including FREEZE cycles.
  - BUSY→IDLE on the edge where the counter=0. mdu_busy=1 exactly MDU_LAT cycles after the issue edge.
  - A mult/div squashed by FLUSH never starts.
- stall_cycles: +1 on each edge where pc_en=0 and reset=1, FREEZE included. Saturates at all-ones and never wraps.
- Register index 0 never causes a load-use hazard.

Test Plan:
- Load-use: lw $5 in EX (ex_memread=1, ex_rt=5), id_rs=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1; stall_cycles=1. Repeat with ex_rt=0 → no stall.
- Branch + load-use together: ex_branch_taken=1, ex_memread=1, ex_rt=id_rt=3 → ifid_flush=idex_flush=1, pc_en=1; no stall.
- Mem freeze: mem_wait=1 for 3 cycles with ex_branch_taken=1 → all en=0, flushes=0 for 3 cycles; 4th cycle flushes assert; stall_cycles=3.
- MDU, MDU_LAT=4: issue mult, then mfhi in ID next cycle → mdu_busy=1 for 4 cycles, ID stalled until mdu_busy=0, then mfhi issues.
- MDU squash: mdu_start=1 with ex_branch_taken=1 → mdu_busy stays 0.
- Reset mid-BUSY (counter=2) and saturation with CNTW=4 (20 stall cycles) → mdu_busy=0 asynchronously, all en=0; stall_cycles holds at 15.
